// File: rtl/bool_op_arbiter_if.sv
// Operand/result bundle between two requesters, the shared logic unit and the consumer.
// No latency: a set of wires only.
// valid/ready on each request port and on the result port.
interface bool_op_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_op;
    logic [CNT_W-1:0] done_cnt;

    // Requester/consumer side.
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, res_op, done_cnt
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, res_op, done_cnt
    );
endinterface

// File: rtl/bool_op_arbiter.sv
// Two requesters share one boolean unit (A MSB=0: A|B, A MSB=1: A^B); round-robin grant,
// or fixed priority to requester 0 when BOOL_OP_ARB_FIXED_PRIO_EN is defined.
// Latency 1 cycle accept->res_valid; single result slot, readys drop while the slot is full and res_ready is low.
module bool_op_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    bool_op_arbiter_if.slave bus
);

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_id_q,    res_id_d;
    logic             res_op_q,    res_op_d;
    logic [CNT_W-1:0] done_cnt_q,  done_cnt_d;
`ifndef BOOL_OP_ARB_FIXED_PRIO_EN
    logic             last_grant_q, last_grant_d;
`endif

    logic             can_accept;
    logic             grant0, grant1;
    logic             acc0, acc1, handoff;
    logic [WIDTH-1:0] sel_a, sel_b;

    // Grant selection; depends only on the valids and the arbitration history.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef BOOL_OP_ARB_FIXED_PRIO_EN
            grant0 = 1'b1;
`else
            // Contention goes to whoever did not win last time.
            if (last_grant_q) grant0 = 1'b1;
            else              grant1 = 1'b1;
`endif
        end else if (bus.req0_valid) begin
            grant0 = 1'b1;
        end else if (bus.req1_valid) begin
            grant1 = 1'b1;
        end
    end

    // Handshake qualifiers; readys are held low while in reset so no outputs move.
    always_comb begin
        can_accept     = !res_valid_q || bus.res_ready;
        bus.req0_ready = grant0 && can_accept && !rst;
        bus.req1_ready = grant1 && can_accept && !rst;
        acc0           = bus.req0_valid && bus.req0_ready;
        acc1           = bus.req1_valid && bus.req1_ready;
        handoff        = res_valid_q && bus.res_ready;
        sel_a          = acc1 ? bus.req1_a : bus.req0_a;
        sel_b          = acc1 ? bus.req1_b : bus.req0_b;
    end

    // Next-state for the result slot, counter and arbitration history.
    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        res_op_d     = res_op_q;
        done_cnt_d   = done_cnt_q;
`ifndef BOOL_OP_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        if (handoff) begin
            // Natural wrap at 2^CNT_W.
            done_cnt_d  = done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            res_valid_d = 1'b0;
        end
        // A new accept refills the slot, including in the same cycle it drains.
        if (acc0 || acc1) begin
            res_valid_d  = 1'b1;
            res_op_d     = sel_a[WIDTH-1];
            res_data_d   = sel_a[WIDTH-1] ? (sel_a ^ sel_b) : (sel_a | sel_b);
            res_id_d     = acc1;
`ifndef BOOL_OP_ARB_FIXED_PRIO_EN
            last_grant_d = acc1;
`endif
        end
    end

    // State registers; reset discards any in-flight result and favours requester 0 next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            res_op_q     <= 1'b0;
            done_cnt_q   <= '0;
`ifndef BOOL_OP_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            res_op_q     <= res_op_d;
            done_cnt_q   <= done_cnt_d;
`ifndef BOOL_OP_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_op    = res_op_q;
    assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_bool_op_arbiter.sv
// Directed-vector bench for bool_op_arbiter with hand-computed expectations.
// Inputs driven 1 time unit after the rising edge; outputs sampled before the next edge.
// Round-robin or fixed-priority expectations chosen by BOOL_OP_ARB_FIXED_PRIO_EN.
module tb_bool_op_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    bool_op_arbiter_if #(.WIDTH(8), .CNT_W(16)) bus ();

    bool_op_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       exp_id;
    logic [7:0] exp_dat;

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
        bus.res_ready  = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_data",  bus.res_data,  0);
        chk("rst_id",    bus.res_id,    0);
        chk("rst_op",    bus.res_op,    0);
        chk("rst_cnt",   bus.done_cnt,  0);
        rst = 1'b0;

        // req0: 0x4D | 0x16 = 0x5F
        bus.req0_valid = 1'b1; bus.req0_a = 8'h4D; bus.req0_b = 8'h16;
        bus.res_ready  = 1'b1;
        #1;
        chk("t1_rdy0", bus.req0_ready, 1);
        chk("t1_rdy1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        chk("t1_valid", bus.res_valid, 1);
        chk("t1_data",  bus.res_data,  8'h5F);
        chk("t1_op",    bus.res_op,    0);
        chk("t1_id",    bus.res_id,    0);
        chk("t1_cnt0",  bus.done_cnt,  0);
        tick();
        chk("t1_drain", bus.res_valid, 0);
        chk("t1_hold",  bus.res_data,  8'h5F);
        chk("t1_cnt1",  bus.done_cnt,  1);

        // req1: 0xCD ^ 0x16 = 0xDB, then 0xFF ^ 0xAA = 0x55 back to back
        bus.req1_valid = 1'b1; bus.req1_a = 8'hCD; bus.req1_b = 8'h16;
        tick();
        chk("t2_data", bus.res_data, 8'hDB);
        chk("t2_op",   bus.res_op,   1);
        chk("t2_id",   bus.res_id,   1);
        bus.req1_a = 8'hFF; bus.req1_b = 8'hAA;
        tick();
        bus.req1_valid = 1'b0;
        chk("t3_data",  bus.res_data,  8'h55);
        chk("t3_op",    bus.res_op,    1);
        chk("t3_valid", bus.res_valid, 1);
        chk("t3_cnt",   bus.done_cnt,  2);
        tick();
        chk("t3_cnt2",  bus.done_cnt,  3);

        // Continuous contention: req0 0x7F|0x7F=0x7F, req1 0x80^0x01=0x81
        bus.req0_valid = 1'b1; bus.req0_a = 8'h7F; bus.req0_b = 8'h7F;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h80; bus.req1_b = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef BOOL_OP_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2 == 1);
`endif
            exp_dat = exp_id ? 8'h81 : 8'h7F;
            chk("rr_valid", bus.res_valid, 1);
            chk("rr_id",    bus.res_id,    exp_id);
            chk("rr_data",  bus.res_data,  exp_dat);
        end
        chk("rr_cnt", bus.done_cnt, 6);

        // Backpressure for 5 cycles, both still valid
        bus.res_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdy0",  bus.req0_ready, 0);
            chk("bp_rdy1",  bus.req1_ready, 0);
            tick();
            chk("bp_valid", bus.res_valid,  1);
            chk("bp_data",  bus.res_data,   exp_dat);
            chk("bp_id",    bus.res_id,     exp_id);
        end
        chk("bp_cnt", bus.done_cnt, 6);
        // Release: drain and accept in the same cycle; req0 is next either way
        bus.res_ready = 1'b1;
        #1;
        chk("rel_rdy0", bus.req0_ready, 1);
        chk("rel_rdy1", bus.req1_ready, 0);
        tick();
        chk("rel_valid", bus.res_valid, 1);
        chk("rel_id",    bus.res_id,    0);
        chk("rel_data",  bus.res_data,  8'h7F);
        chk("rel_cnt",   bus.done_cnt,  7);

        // Asynchronous reset in the middle of backpressure
        bus.res_ready = 1'b0;
        tick();
        chk("pre_rst_valid", bus.res_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.res_valid,  0);
        chk("arst_data",  bus.res_data,   0);
        chk("arst_cnt",   bus.done_cnt,   0);
        chk("arst_rdy0",  bus.req0_ready, 0);
        chk("arst_rdy1",  bus.req1_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy0", bus.req0_ready, 1);
        chk("post_rst_rdy1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("post_rst_id",   bus.res_id,   0);
        chk("post_rst_data", bus.res_data, 8'h7F);
        bus.res_ready = 1'b1;
        tick();
        chk("post_rst_cnt", bus.done_cnt, 1);

        // Counter wrap: fresh reset, then 65535 hand-offs, then one more
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
        bus.res_ready  = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap_max", bus.done_cnt, 16'hFFFF);
        bus.req0_valid = 1'b0;
        tick();
        chk("wrap_zero",  bus.done_cnt,  16'h0000);
        chk("wrap_valid", bus.res_valid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
